uart_bfm: RTL and testbench

Clocked UART bus-functional model for the SoC simulation bench. It replaces the bench's delay-based, fixed-format UART sender with a parametrised transmitter and receiver running on the bench clock. The transmitter drives the SoC `io_uart_rx` pin. The receiver monitors `io_uart_tx`. Deliberate framing and parity errors can be injected per byte.

---
 rtl/uart_bfm.sv | 211 +++++++++++++++++++++
 tb/tb_uart_bfm.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bfm.sv
// Clocked UART bus-functional model: parametrised transmitter with per-byte
// framing/parity error injection, and an independent receiver behind a 2-flop synchroniser.
//
// state        | meaning
// TX_IDLE      | line high, tx_ready high, waiting for an accept
// TX_START     | driving the start bit (0)
// TX_DATA      | shifting data out LSB first
// TX_PARITY    | driving the (possibly inverted) parity bit
// TX_STOP      | driving stop bit(s); first one forced low on frame injection
// TX_GAP       | enforced idle-high time before the next accept
// RX_IDLE      | watching the synchronised line for a falling edge
// RX_START     | half-bit wait, then confirm the start bit (glitch filter)
// RX_DATA      | sampling data bits at bit centres
// RX_PARITY    | sampling the parity bit
// RX_STOP      | sampling the first stop bit, publishing the frame
// RX_WAIT_HIGH | after a frame error, waiting for the line to return high
module uart_bfm #(
    parameter int CLK_DIV   = 5,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_inj_frame,
    input  logic                 tx_inj_parity,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic [31:0]          tx_count,
    output logic [31:0]          rx_count
);

    localparam int TW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam int HALF = (CLK_DIV + 1) / 2;
    localparam logic [TW-1:0] T_BIT  = TW'(CLK_DIV);
    localparam logic [TW-1:0] T_HALF = TW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic PAR_EN  = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_GAP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    tx_state_t             tx_state, tx_next;
    logic [TW-1:0]         tx_timer;
    logic [3:0]            tx_bits;
    logic [DATA_BITS-1:0]  tx_shift;
    logic                  tx_par, tx_frame_q, tx_line, tx_tick, tx_accept;
    logic [31:0]           tx_count_q;

    rx_state_t             rx_state, rx_next;
    logic                  rx_meta, rx_sync, rx_prev, rx_tick, rx_par_bit;
    logic [TW-1:0]         rx_timer;
    logic [3:0]            rx_bits;
    logic [DATA_BITS-1:0]  rx_shift, rx_data_q;
    logic                  rx_valid_q, rx_fe_q, rx_pe_q;
    logic [31:0]           rx_count_q;

    assign tx_ready  = (tx_state == TX_IDLE);
    assign tx_accept = tx_valid & tx_ready;
    assign tx_tick   = (tx_timer == '0);
    assign uart_tx   = tx_line;
    assign tx_count  = tx_count_q;

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_line = 1'b1;
        unique case (tx_state)
            TX_IDLE:   if (tx_valid) tx_next = TX_START;
            TX_START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_tick && tx_bits == 4'd0) tx_next = PAR_EN ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_tick) tx_next = TX_STOP;
            end
            TX_STOP: begin
                // Only the first stop bit carries the injected framing error
                tx_line = !(tx_frame_q && tx_bits == 4'(STOP_BITS - 1));
                if (tx_tick && tx_bits == 4'd0) tx_next = (GAP_BITS != 0) ? TX_GAP : TX_IDLE;
            end
            TX_GAP:    if (tx_tick && tx_bits == 4'd0) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_timer   <= '0;
            tx_bits    <= '0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            tx_frame_q <= 1'b0;
            tx_count_q <= '0;
        end else begin
            if (tx_state != TX_IDLE) tx_timer <= tx_tick ? T_BIT : tx_timer - 1'b1;
            case (tx_state)
                TX_IDLE: if (tx_accept) begin
                    tx_timer   <= T_BIT;
                    tx_shift   <= tx_data;
                    tx_par     <= ^tx_data ^ PAR_ODD ^ (tx_inj_parity & PAR_EN);
                    tx_frame_q <= tx_inj_frame;
                end
                TX_START: if (tx_tick) tx_bits <= 4'(DATA_BITS - 1);
                TX_DATA: if (tx_tick) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bits  <= (tx_bits == 4'd0) ? 4'(STOP_BITS - 1) : tx_bits - 1'b1;
                end
                TX_STOP: if (tx_tick) begin
                    if (tx_bits == 4'd0) begin
                        tx_bits    <= 4'(GAP_BITS - 1);
                        tx_count_q <= tx_count_q + 32'd1;
                    end else begin
                        tx_bits <= tx_bits - 1'b1;
                    end
                end
                TX_GAP: if (tx_tick && tx_bits != 4'd0) tx_bits <= tx_bits - 1'b1;
                default: ;
            endcase
        end
    end

    assign rx_tick       = (rx_timer == '0);
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_frame_err  = rx_fe_q;
    assign rx_parity_err = rx_pe_q;
    assign rx_count      = rx_count_q;

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:      if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START:     if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_tick && rx_bits == 4'd0) rx_next = PAR_EN ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_tick) rx_next = RX_STOP;
            RX_STOP:      if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_timer   <= '0;
            rx_bits    <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_fe_q    <= 1'b0;
            rx_pe_q    <= 1'b0;
            rx_count_q <= '0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_valid_q <= 1'b0;
            // Idle keeps the half-bit delay preloaded so START samples mid-bit
            if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH) rx_timer <= T_HALF;
            else rx_timer <= rx_tick ? T_BIT : rx_timer - 1'b1;
            case (rx_state)
                RX_START: if (rx_tick) rx_bits <= 4'(DATA_BITS - 1);
                RX_DATA: if (rx_tick) begin
                    rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_bits != 4'd0) rx_bits <= rx_bits - 1'b1;
                end
                RX_PARITY: if (rx_tick) rx_par_bit <= rx_sync;
                RX_STOP: if (rx_tick) begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= rx_shift;
                    rx_fe_q    <= ~rx_sync;
                    rx_pe_q    <= PAR_EN & ((^rx_shift ^ PAR_ODD) != rx_par_bit);
                    rx_count_q <= rx_count_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bfm.sv
// Bench for uart_bfm: three instances (8N1, 8E1, 7O2) with selectable loopback,
// received frames scored against an expected-frame queue.
`timescale 1ns/1ps
module tb_uart_bfm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  tx_valid, tx_ready, inj_f, inj_p, uart_tx, uart_rx;
    logic [2:0]  rx_valid, fe, pe, loop, force_rx;
    logic [7:0]  tx_data [3];
    logic [7:0]  rx_data [3];
    logic [7:0]  rx_data_a, rx_data_b;
    logic [6:0]  rx_data_c;
    logic [31:0] tx_count [3];
    logic [31:0] rx_count [3];
    int          cyc = 0;

    assign uart_rx    = (loop & uart_tx) | (~loop & force_rx);
    assign rx_data[0] = rx_data_a;
    assign rx_data[1] = rx_data_b;
    assign rx_data[2] = {1'b0, rx_data_c};

    always @(posedge clk) cyc <= cyc + 1;

    uart_bfm #(.CLK_DIV(5), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_BITS(1)) u_a (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_data(tx_data[0]), .tx_inj_frame(inj_f[0]), .tx_inj_parity(inj_p[0]),
        .uart_tx(uart_tx[0]), .uart_rx(uart_rx[0]), .rx_valid(rx_valid[0]),
        .rx_data(rx_data_a), .rx_frame_err(fe[0]), .rx_parity_err(pe[0]),
        .tx_count(tx_count[0]), .rx_count(rx_count[0]));

    uart_bfm #(.CLK_DIV(5), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .GAP_BITS(1)) u_b (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_data(tx_data[1]), .tx_inj_frame(inj_f[1]), .tx_inj_parity(inj_p[1]),
        .uart_tx(uart_tx[1]), .uart_rx(uart_rx[1]), .rx_valid(rx_valid[1]),
        .rx_data(rx_data_b), .rx_frame_err(fe[1]), .rx_parity_err(pe[1]),
        .tx_count(tx_count[1]), .rx_count(rx_count[1]));

    uart_bfm #(.CLK_DIV(5), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .GAP_BITS(1)) u_c (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .tx_data(tx_data[2][6:0]), .tx_inj_frame(inj_f[2]), .tx_inj_parity(inj_p[2]),
        .uart_tx(uart_tx[2]), .uart_rx(uart_rx[2]), .rx_valid(rx_valid[2]),
        .rx_data(rx_data_c), .rx_frame_err(fe[2]), .rx_parity_err(pe[2]),
        .tx_count(tx_count[2]), .rx_count(rx_count[2]));

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    // Scoreboard: every rx_valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rx_valid[i] === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_unexpected inst %0d: got frame data %h, required no frame", i, rx_data[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.inst != i || rx_data[i] !== mon_e.data || fe[i] !== mon_e.fe || pe[i] !== mon_e.pe) begin
                        n_fail++;
                        $display("FAIL rx_frame inst %0d: got data %h fe %b pe %b, required inst %0d data %h fe %b pe %b",
                                 i, rx_data[i], fe[i], pe[i], mon_e.inst, mon_e.data, mon_e.fe, mon_e.pe);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tx_valid = 3'b000;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns #1 after the accept edge; the next negedge is frame sample 0
    task automatic send(input int i, input logic [7:0] d, input logic f, input logic p, input logic pe_exp);
        int t = 0;
        @(negedge clk);
        while (tx_ready[i] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 500) begin
            n_fail++;
            $display("FAIL send_ready inst %0d: tx_ready %b after 500 clocks, required 1", i, tx_ready[i]);
        end
        tx_valid[i] = 1'b1;
        tx_data[i]  = d;
        inj_f[i]    = f;
        inj_p[i]    = p;
        exp_q.push_back('{i, d, f, pe_exp});
        @(posedge clk);
        #1;
        tx_valid[i] = 1'b0;
        tx_data[i]  = ~d;
        inj_f[i]    = ~f;
        inj_p[i]    = ~p;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d frames still pending after %0d clocks, required 0", exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks += 8;
            if (uart_tx[i] !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx inst %0d: got %b, required 1", i, uart_tx[i]); end
            if (tx_ready[i] !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready inst %0d: got %b, required 1", i, tx_ready[i]); end
            if (rx_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid inst %0d: got %b, required 0", i, rx_valid[i]); end
            if (rx_data[i] !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data inst %0d: got %h, required 00", i, rx_data[i]); end
            if (fe[i] !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err inst %0d: got %b, required 0", i, fe[i]); end
            if (pe[i] !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err inst %0d: got %b, required 0", i, pe[i]); end
            if (tx_count[i] !== 32'd0) begin n_fail++; $display("FAIL reset_tx_count inst %0d: got %0d, required 0", i, tx_count[i]); end
            if (rx_count[i] !== 32'd0) begin n_fail++; $display("FAIL reset_rx_count inst %0d: got %0d, required 0", i, rx_count[i]); end
        end
    endtask

    task automatic test_frame_a5();
        logic [7:0] d = 8'hA5;
        logic       el;
        int         b;
        int         frame_clks = (1 + 8 + 0 + 1 + 1) * 6;
        do_reset();
        send(0, d, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j <= frame_clks; j++) begin
            @(negedge clk);
            b = j / 6;
            if (b == 0) el = 1'b0;
            else if (b <= 8) el = d[b-1];
            else el = 1'b1;
            n_checks += 2;
            if (uart_tx[0] !== el) begin n_fail++; $display("FAIL a5_line clk %0d: got %b, required %b", j, uart_tx[0], el); end
            if (tx_ready[0] !== (j >= frame_clks)) begin
                n_fail++; $display("FAIL a5_ready clk %0d: got %b, required %b", j, tx_ready[0], (j >= frame_clks));
            end
        end
        drain(200);
        n_checks += 2;
        if (tx_count[0] !== 32'd1) begin n_fail++; $display("FAIL a5_tx_count: got %0d, required 1", tx_count[0]); end
        if (rx_count[0] !== 32'd1) begin n_fail++; $display("FAIL a5_rx_count: got %0d, required 1", rx_count[0]); end
    endtask

    task automatic test_parity();
        logic [7:0] d [3] = '{8'h03, 8'h07, 8'h07};
        logic       ip [3] = '{1'b0, 1'b1, 1'b0};
        logic       el;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(1, d[k], 1'b0, ip[k], ip[k]);
            repeat (58) @(negedge clk);
            el = (^d[k]) ^ ip[k];
            n_checks++;
            if (uart_tx[1] !== el) begin n_fail++; $display("FAIL parity_bit frame %0d: got %b, required %b", k, uart_tx[1], el); end
        end
        drain(200);
        n_checks++;
        if (rx_count[1] !== 32'd3) begin n_fail++; $display("FAIL parity_rx_count: got %0d, required 3", rx_count[1]); end
    endtask

    task automatic test_frame_inject();
        do_reset();
        send(0, 8'h3C, 1'b1, 1'b0, 1'b0);
        repeat (58) @(negedge clk);
        n_checks++;
        if (uart_tx[0] !== 1'b0) begin n_fail++; $display("FAIL inject_stop_bit: got %b, required 0", uart_tx[0]); end
        send(0, 8'h41, 1'b0, 1'b0, 1'b0);
        repeat (58) @(negedge clk);
        n_checks++;
        if (uart_tx[0] !== 1'b1) begin n_fail++; $display("FAIL clean_stop_bit: got %b, required 1", uart_tx[0]); end
        drain(200);
        n_checks += 2;
        if (rx_count[0] !== 32'd2) begin n_fail++; $display("FAIL inject_rx_count: got %0d, required 2", rx_count[0]); end
        if (tx_count[0] !== 32'd2) begin n_fail++; $display("FAIL inject_tx_count: got %0d, required 2", tx_count[0]); end
    endtask

    task automatic test_glitch();
        do_reset();
        loop[0] = 1'b0;
        force_rx[0] = 1'b1;
        repeat (5) @(negedge clk);
        force_rx[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        force_rx[0] = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (rx_count[0] !== 32'd0) begin n_fail++; $display("FAIL glitch_rx_count: got %0d, required 0", rx_count[0]); end
        loop[0] = 1'b1;
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        drain(200);
        n_checks++;
        if (rx_count[0] !== 32'd1) begin n_fail++; $display("FAIL post_glitch_rx_count: got %0d, required 1", rx_count[0]); end
    endtask

    task automatic test_reset_mid();
        int n_low = 0;
        do_reset();
        send(0, 8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0] = 8'h55;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tx_valid[0] = 1'b0;
        @(negedge clk);
        n_checks += 4;
        if (uart_tx[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_uart_tx: got %b, required 1", uart_tx[0]); end
        if (tx_ready[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_tx_ready: got %b, required 1", tx_ready[0]); end
        if (tx_count[0] !== 32'd0) begin n_fail++; $display("FAIL midreset_tx_count: got %0d, required 0", tx_count[0]); end
        if (rx_count[0] !== 32'd0) begin n_fail++; $display("FAIL midreset_rx_count: got %0d, required 0", rx_count[0]); end
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (uart_tx[0] !== 1'b1) n_low++;
        end
        n_checks += 2;
        if (n_low !== 0) begin n_fail++; $display("FAIL midreset_line_idle: got %0d low clocks, required 0", n_low); end
        if (rx_count[0] !== 32'd0) begin n_fail++; $display("FAIL midreset_rx_after: got %0d, required 0", rx_count[0]); end
    endtask

    task automatic test_seven_bit();
        int frame_clks = (1 + 7 + 1 + 2 + 1) * 6;
        do_reset();
        send(2, 8'h7F, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j <= frame_clks; j++) begin
            @(negedge clk);
            if (j == 51 || j == 57 || j == 63) begin
                n_checks++;
                if (uart_tx[2] !== (j != 51)) begin
                    n_fail++; $display("FAIL seven_line clk %0d: got %b, required %b", j, uart_tx[2], (j != 51));
                end
            end
            if (j == frame_clks - 1 || j == frame_clks) begin
                n_checks++;
                if (tx_ready[2] !== (j == frame_clks)) begin
                    n_fail++; $display("FAIL seven_ready clk %0d: got %b, required %b", j, tx_ready[2], (j == frame_clks));
                end
            end
        end
        drain(200);
        n_checks += 2;
        if (rx_count[2] !== 32'd1) begin n_fail++; $display("FAIL seven_rx_count: got %0d, required 1", rx_count[2]); end
        if (tx_count[2] !== 32'd1) begin n_fail++; $display("FAIL seven_tx_count: got %0d, required 1", tx_count[2]); end
    endtask

    task automatic test_back_to_back();
        int spacing = (1 + 8 + 0 + 1 + 1) * 6 + 1;
        int prev_acc = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
            if (k > 0) begin
                n_checks++;
                if (cyc - prev_acc !== spacing) begin
                    n_fail++; $display("FAIL b2b_spacing frame %0d: got %0d clocks, required %0d", k, cyc - prev_acc, spacing);
                end
            end
            prev_acc = cyc;
        end
        drain(300);
        n_checks += 2;
        if (tx_count[0] !== 32'd4) begin n_fail++; $display("FAIL b2b_tx_count: got %0d, required 4", tx_count[0]); end
        if (rx_count[0] !== 32'd4) begin n_fail++; $display("FAIL b2b_rx_count: got %0d, required 4", rx_count[0]); end
    endtask

    initial begin
        reset    = 1'b1;
        tx_valid = 3'b000;
        inj_f    = 3'b000;
        inj_p    = 3'b000;
        loop     = 3'b111;
        force_rx = 3'b111;
        for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
        test_reset();
        test_frame_a5();
        test_parity();
        test_frame_inject();
        test_glitch();
        test_reset_mid();
        test_seven_bit();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
